// File: rtl/int_to_float_pipe.sv
// int_to_float_pipe: valid/ready integer to IEEE-754 single converter with tag passthrough.
// Define INT_TO_FLOAT_PIPE_FIXED_POINT_EN to add the frac_bits input (result scaled by 2^-frac_bits).
module int_to_float_pipe #(
  parameter int IN_WIDTH  = 32,
  parameter int LATENCY   = 4,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  a,
  input  logic                 is_signed,
  input  logic                 rnd_mode,
  input  logic [TAG_WIDTH-1:0] in_tag,
`ifdef INT_TO_FLOAT_PIPE_FIXED_POINT_EN
  input  logic [5:0]           frac_bits,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          q,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 inexact,
  output logic                 is_zero
);
  // Normalised width keeps 23 fraction bits, guard and at least one sticky bit.
  localparam int E = IN_WIDTH > 26 ? IN_WIDTH : 26;

  typedef struct packed {
    logic                 v;
    logic                 sgn;
    logic                 rnd;
    logic [5:0]           fb;
    logic [IN_WIDTH-1:0]  mag;
    logic [TAG_WIDTH-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic                 v;
    logic                 sgn;
    logic                 rnd;
    logic [7:0]           exp;
    logic [E-1:0]         norm;
    logic [TAG_WIDTH-1:0] tag;
  } mid_t;

  typedef struct packed {
    logic                 v;
    logic [31:0]          q;
    logic [TAG_WIDTH-1:0] tag;
    logic                 inx;
    logic                 z;
  } out_t;

  s1_t         s1_d, s1_q;
  mid_t        mid_d, rin;
  out_t        out_d, out_q;
  logic        stall;
  logic [6:0]  p;
  logic [22:0] frac;
  logic        g, st, inc;
  logic [23:0] frac_r;

  assign stall    = out_q.v && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    s1_d.v   = in_valid;
    s1_d.sgn = is_signed && a[IN_WIDTH-1];
    s1_d.rnd = rnd_mode;
    s1_d.mag = s1_d.sgn ? -a : a;
    s1_d.tag = in_tag;
`ifdef INT_TO_FLOAT_PIPE_FIXED_POINT_EN
    s1_d.fb  = frac_bits > 6'(IN_WIDTH - 1) ? 6'(IN_WIDTH - 1) : frac_bits;
`else
    s1_d.fb  = '0;
`endif
  end

  always_ff @(posedge clk or posedge areset)
    if (areset) s1_q <= '0;
    else if (!stall) s1_q <= s1_d;

  // Leading-one detect, then left-align so the hidden bit sits at norm[E-1].
  always_comb begin
    p = '0;
    for (int i = 0; i < IN_WIDTH; i++) if (s1_q.mag[i]) p = 7'(i);
    mid_d.v    = s1_q.v;
    mid_d.sgn  = s1_q.sgn;
    mid_d.rnd  = s1_q.rnd;
    mid_d.tag  = s1_q.tag;
    mid_d.norm = E'(s1_q.mag) << (7'(E - 1) - p);
    mid_d.exp  = 8'(9'd127 + 9'(p) - 9'(s1_q.fb));
  end

  generate
    if (LATENCY == 2) begin : g_nomid
      assign rin = mid_d;
    end else begin : g_mid
      mid_t pipe_q [LATENCY-2];
      always_ff @(posedge clk or posedge areset)
        if (areset) begin
          for (int i = 0; i < LATENCY - 2; i++) pipe_q[i] <= '0;
        end else if (!stall) begin
          pipe_q[0] <= mid_d;
          for (int i = 1; i < LATENCY - 2; i++) pipe_q[i] <= pipe_q[i-1];
        end
      assign rin = pipe_q[LATENCY-3];
    end
  endgenerate

  // Round and pack; a fraction carry-out wraps to zero and bumps the exponent.
  always_comb begin
    frac    = rin.norm[E-2 -: 23];
    g       = rin.norm[E-25];
    st      = |rin.norm[E-26:0];
    inc     = !rin.rnd && g && (st || frac[0]);
    frac_r  = {1'b0, frac} + 24'(inc);
    out_d.v   = rin.v;
    out_d.z   = rin.v && !rin.norm[E-1];
    out_d.inx = rin.v && (g || st);
    out_d.tag = rin.v ? rin.tag : '0;
    out_d.q   = (rin.v && rin.norm[E-1]) ? {rin.sgn, rin.exp + 8'(frac_r[23]), frac_r[22:0]} : '0;
  end

  always_ff @(posedge clk or posedge areset)
    if (areset) out_q <= '0;
    else if (!stall) out_q <= out_d;

  assign out_valid = out_q.v;
  assign q         = out_q.q;
  assign out_tag   = out_q.tag;
  assign inexact   = out_q.inx;
  assign is_zero   = out_q.z;
endmodule

// File: tb/tb_int_to_float_pipe.sv
// tb_int_to_float_pipe: randomized and directed checks of int_to_float_pipe against an arithmetic float model.
module tb_int_to_float_pipe;
  localparam int W = 32, L = 4, T = 4;

  logic         clk = 0, areset = 1, in_valid = 0, is_signed = 0, rnd_mode = 0, out_ready = 1;
  logic         in_ready, out_valid, inexact, is_zero;
  logic [W-1:0] a = '0;
  logic [T-1:0] in_tag = '0, out_tag;
  logic [31:0]  q;
`ifdef INT_TO_FLOAT_PIPE_FIXED_POINT_EN
  logic [5:0]   frac_bits = '0;
`endif

  int checks = 0, errors = 0, cyc = 0, stall_cnt = 0, stall_seen = 0;
  bit rand_rdy = 0;

  typedef struct {
    logic [31:0] q;
    logic [T-1:0] tag;
    logic inx;
    logic z;
    int acc;
    bit lat;
  } exp_t;
  exp_t sb[$];
  exp_t me;

  int_to_float_pipe #(.IN_WIDTH(W), .LATENCY(L), .TAG_WIDTH(T)) dut (
    .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .is_signed(is_signed), .rnd_mode(rnd_mode), .in_tag(in_tag),
`ifdef INT_TO_FLOAT_PIPE_FIXED_POINT_EN
    .frac_bits(frac_bits),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .out_tag(out_tag),
    .inexact(inexact), .is_zero(is_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Float value from the integer by plain arithmetic: scale mantissa to 24 bits, round on the remainder.
  function automatic exp_t model(input logic [31:0] av, input logic sg, input logic rd, input logic [T-1:0] tg, input int fb);
    exp_t r;
    longint unsigned mag, man, rem, half;
    bit neg;
    int p, e;
    neg = sg && av[31];
    mag = neg ? 64'h1_0000_0000 - {32'd0, av} : {32'd0, av};
    r.tag = tg; r.acc = 0; r.lat = 0;
    if (mag == 0) begin
      r.q = 0; r.inx = 0; r.z = 1;
      return r;
    end
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    if (p <= 23) begin
      man = mag << (23 - p); rem = 0; half = 0;
    end else begin
      man = mag >> (p - 23); rem = mag % (64'd1 << (p - 23)); half = 64'd1 << (p - 24);
    end
    if (!rd && p > 23 && (rem > half || (rem == half && man[0]))) man++;
    e = 127 + p - (fb > 31 ? 31 : fb);
    if (man == (64'd1 << 24)) begin
      man = 64'd1 << 23; e++;
    end
    r.q = {neg, 8'(e), man[22:0]};
    r.inx = rem != 0;
    r.z = 0;
    return r;
  endfunction

  function automatic logic [31:0] rand_a();
    int k;
    k = $urandom_range(0, 31);
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 300));
      2: return (32'd1 << k) + 32'($urandom_range(0, 2)) - 32'd1;
      default: return (32'd1 << 24 | 32'($urandom_range(0, 15))) << $urandom_range(0, 7);
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      out_ready = 0;
      stall_cnt--;
    end else out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (areset) check("rst_outputs", {out_valid, q, out_tag, inexact, is_zero}, 0);
    else if (!out_valid) check("gate", {q, out_tag, inexact, is_zero}, 0);
    else if (sb.size() == 0) check("unexpected_out", 1, 0);
    else if (!out_ready) begin
      stall_seen++;
      check("stall_in_ready", in_ready, 0);
      check("stall_q", q, sb[0].q);
      check("stall_tag", out_tag, sb[0].tag);
    end else begin
      me = sb.pop_front();
      check("q", q, me.q);
      check("tag", out_tag, me.tag);
      check("inexact", inexact, me.inx);
      check("is_zero", is_zero, me.z);
      if (me.lat) check("latency", cyc - me.acc, L);
    end
  end

  task automatic send(input logic [31:0] av, input logic sg, input logic rd, input logic [T-1:0] tg,
                      input int fb, input bit lat, input bit use_k, input logic [31:0] kq);
    int n;
    exp_t e;
    n = 0;
    a = av; is_signed = sg; rnd_mode = rd; in_tag = tg; in_valid = 1;
`ifdef INT_TO_FLOAT_PIPE_FIXED_POINT_EN
    frac_bits = 6'(fb);
`endif
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    else begin
      e = model(av, sg, rd, tg, fb);
      if (use_k) e.q = kq;
      e.acc = cyc;
      e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    in_valid = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    idle(3);
    check(tag, sb.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    @(posedge clk); #1 areset = 0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    send(32'd1, 1, 0, 4'd1, 0, 1, 1, 32'h3F800000);
    in_valid = 0;
    idle(8);
    send(32'hFFFFFFFF, 1, 0, 4'd2, 0, 0, 1, 32'hBF800000);
    send(32'h80000000, 1, 0, 4'd3, 0, 0, 1, 32'hCF000000);
    send(32'hFFFFFFFF, 0, 0, 4'd4, 0, 0, 1, 32'h4F800000);
    send(32'hFFFFFFFF, 0, 1, 4'd5, 0, 0, 1, 32'h4F7FFFFF);
    send(32'd16777217, 1, 0, 4'd6, 0, 0, 1, 32'h4B800000);
    send(32'd16777219, 1, 0, 4'd7, 0, 0, 1, 32'h4B800002);
    send(32'd0, 1, 0, 4'd8, 0, 0, 1, 32'h00000000);
    drain("drain_directed");

    for (int i = 0; i < 8; i++) begin
      if (i == 3) stall_cnt = 5;
      send(i == 4 ? 32'd0 : $urandom, 1'($urandom), 0, 4'(i), 0, 0, 0, 0);
    end
    drain("drain_backpressure");

`ifdef INT_TO_FLOAT_PIPE_FIXED_POINT_EN
    send(32'd3, 1, 0, 4'd9, 1, 0, 1, 32'h3FC00000);
    send(32'd1, 1, 0, 4'd10, 40, 0, 1, 32'h30000000);
    send(32'd0, 1, 0, 4'd11, 5, 0, 1, 32'h00000000);
    drain("drain_fixed");
`endif

    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 0;
        idle(1);
      end
`ifdef INT_TO_FLOAT_PIPE_FIXED_POINT_EN
      send(rand_a(), 1'($urandom), 1'($urandom), 4'($urandom), $urandom_range(0, 40), 0, 0, 0);
`else
      send(rand_a(), 1'($urandom), 1'($urandom), 4'($urandom), 0, 0, 0, 0);
`endif
    end
    rand_rdy = 0;
    drain("drain_random");

    stall_cnt = 1000;
    for (int i = 0; i < 3; i++) send(32'd100 + 32'(i), 1, 0, 4'(12 + i), 0, 0, 0, 0);
    in_valid = 0;
    idle(6);
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    #2 areset = 1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_q", q, 0);
    check("rst_flags", {out_tag, inexact, is_zero}, 0);
    check("rst_in_ready", in_ready, 1);
    sb.delete();
    stall_cnt = 0;
    @(posedge clk); #3 areset = 0;
    idle(12);
    check("no_stale", sb.size(), 0);
    check("stall_seen", stall_seen > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
